// File: rtl/db3_pkg.sv
// Shared definitions for the db3 word arbiter: FSM state encodings, residue
// constants and the mod-3 residue transition function.
package db3_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam logic [1:0] REM0 = 2'b00;
    localparam logic [1:0] REM1 = 2'b01;
    localparam logic [1:0] REM2 = 2'b10;

    // Next residue after appending one bit MSB-first: r' = (2r + b) mod 3.
    // The unused 2'b11 encoding recovers to REM0.
    function automatic logic [1:0] mod3_next(input logic [1:0] r, input logic b);
        logic [1:0] n;
        case (r)
            REM0:    n = b ? REM1 : REM0;
            REM1:    n = b ? REM0 : REM2;
            REM2:    n = b ? REM2 : REM1;
            default: n = REM0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mod3_residue.sv
// Bit-serial mod-3 residue engine: accumulates one bit per enabled clock,
// MSB first, and keeps the running remainder and a divisible-by-3 flag.
module mod3_residue
    import db3_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       bit_en,
    input  logic       bit_in,
    output logic [1:0] rem,
    output logic       div
);

    logic [1:0] rem_r;
    logic [1:0] rem_nxt_s;
    logic       div_r;

    assign rem_nxt_s = mod3_next(rem_r, bit_in);

    // Residue register: clear on a new word, advance on each shifted bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem_r <= REM0;
            div_r <= 1'b1;
        end else if (clr) begin
            rem_r <= REM0;
            div_r <= 1'b1;
        end else if (bit_en) begin
            rem_r <= rem_nxt_s;
            div_r <= (rem_nxt_s == REM0);
        end else begin
            rem_r <= rem_r;
            div_r <= div_r;
        end
    end

    assign rem = rem_r;
    assign div = div_r;

endmodule

// File: rtl/db3_word_arbiter.sv
// Round-robin arbiter feeding N requester words, MSB first, into one shared
// serial mod-3 residue engine and returning remainder, flag and requester id.
module db3_word_arbiter
    import db3_pkg::*;
#(
    parameter int W   = 8,
    parameter int N   = 2,
    parameter int IDW = 1
)
(
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req_valid,
    input  logic [N*W-1:0] req_data,
    output logic [N-1:0]   req_ready,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [IDW-1:0] res_id,
    output logic [1:0]     res_rem,
    output logic           res_div,
    output logic           busy
);

    localparam int CW = $clog2(W + 1);

    state_t         state_r;
    logic [IDW-1:0] ptr_r;
    logic [IDW-1:0] id_r;
    logic [W-1:0]   shreg_r;
    logic [CW-1:0]  cnt_r;
    logic           res_valid_r;

    logic [N-1:0]   upper_s;
    logic [N-1:0]   pick_s;
    logic [IDW-1:0] grant_s;
    logic [W-1:0]   word_s;
    logic           accept_s;
    logic [1:0]     rem_s;
    logic           div_s;

    // Round-robin pick: lowest valid index at or above ptr, else wrap to the
    // lowest valid index overall. Accept is suppressed while reset is held.
    always_comb begin
        upper_s  = {N{1'b0}};
        grant_s  = {IDW{1'b0}};
        word_s   = {W{1'b0}};
        accept_s = rst && (state_r == IDLE) && (|req_valid);
        for (int i = 0; i < N; i++) begin
            upper_s[i] = req_valid[i] && (IDW'(i) >= ptr_r);
        end
        pick_s = (upper_s != {N{1'b0}}) ? upper_s : req_valid;
        for (int i = N - 1; i >= 0; i--) begin
            grant_s = pick_s[i] ? IDW'(i) : grant_s;
        end
        for (int i = 0; i < N; i++) begin
            req_ready[i] = accept_s && (grant_s == IDW'(i));
            word_s       = (grant_s == IDW'(i)) ? req_data[i*W +: W] : word_s;
        end
    end

    // Control FSM with shift register, bit counter, pointer and result valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            ptr_r       <= {IDW{1'b0}};
            id_r        <= {IDW{1'b0}};
            shreg_r     <= {W{1'b0}};
            cnt_r       <= {CW{1'b0}};
            res_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        shreg_r <= word_s;
                        id_r    <= grant_s;
                        cnt_r   <= CW'(W);
                        ptr_r   <= (grant_s == IDW'(N - 1)) ? {IDW{1'b0}}
                                                             : grant_s + IDW'(1);
                        state_r <= SHIFT;
                    end
                end
                SHIFT: begin
                    shreg_r <= {shreg_r[W-2:0], 1'b0};
                    cnt_r   <= cnt_r - CW'(1);
                    if (cnt_r == CW'(1)) begin
                        res_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    res_valid_r <= 1'b0;
                    cnt_r       <= {CW{1'b0}};
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    mod3_residue u_residue (
        .clk    (clk),
        .rst    (rst),
        .clr    (accept_s),
        .bit_en (state_r == SHIFT),
        .bit_in (shreg_r[W-1]),
        .rem    (rem_s),
        .div    (div_s)
    );

    // Result fields only show the engine contents while a result is offered.
    assign res_valid = res_valid_r;
    assign res_id    = id_r;
    assign res_rem   = res_valid_r ? rem_s : REM0;
    assign res_div   = res_valid_r & div_s;
    assign busy      = (state_r != IDLE);

endmodule
